// File: rtl/lcd_read_fsm.sv
// lcd_read_fsm: reads one byte (BF/address or data) from an HD44780 LCD over its 4-bit bus.
// Define LCD_BUSY_POLL_EN to add busy-flag polling (rd_poll, rd_timeout, POLL_MAX).
module lcd_read_fsm #(
    parameter int unsigned SETUP_CYC      = 2,
    parameter int unsigned E_HIGH_CYC     = 12,
    parameter int unsigned SAMPLE_CYC     = 10,
    parameter int unsigned NIBBLE_GAP_CYC = 50,
    parameter int unsigned HOLD_CYC       = 1
`ifdef LCD_BUSY_POLL_EN
    ,
    parameter int unsigned POLL_MAX       = 1000
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rd_start,
    input  logic       rd_rs,
`ifdef LCD_BUSY_POLL_EN
    input  logic       rd_poll,
    output logic       rd_timeout,
`endif
    output logic       rd_busy,
    output logic       rd_done,
    output logic [7:0] rd_data,
    output logic       busy_flag,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_db_oe,
    input  logic [3:0] lcd_db_in
);
    typedef enum logic [2:0] {IDLE, SETUP, EHI1, GAP, EHI2, HOLD, DONE, PGAP} state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        lcd_e_q, lcd_rw_q, lcd_rs_q, busy_flag_q;
    logic [3:0]  nib_hi_q, nib_lo_q;
    logic [7:0]  rd_data_q;
    logic        expire, sample, repeat_rd;

    assign expire = cnt_q == 16'd0;
    assign sample = cnt_q == 16'(E_HIGH_CYC - SAMPLE_CYC);

`ifdef LCD_BUSY_POLL_EN
    logic        poll_q, timeout_q;
    logic [15:0] polls_q;

    assign repeat_rd  = poll_q & nib_hi_q[3] & (polls_q != 16'(POLL_MAX - 1));
    assign rd_timeout = (state_q == DONE) & timeout_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            poll_q    <= 1'b0;
            timeout_q <= 1'b0;
            polls_q   <= 16'd0;
        end else if (state_q == IDLE && rd_start) begin
            poll_q    <= rd_poll & ~rd_rs;
            timeout_q <= 1'b0;
            polls_q   <= 16'd0;
        end else if (state_q == HOLD && expire) begin
            polls_q   <= repeat_rd ? polls_q + 16'd1 : polls_q;
            timeout_q <= poll_q & nib_hi_q[3] & ~repeat_rd;
        end
    end
`else
    assign repeat_rd = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = expire ? 16'd0 : cnt_q - 16'd1;
        case (state_q)
            IDLE:  if (rd_start) begin state_d = SETUP; cnt_d = 16'(SETUP_CYC - 1); end
            SETUP: if (expire) begin state_d = EHI1; cnt_d = 16'(E_HIGH_CYC - 1); end
            EHI1:  if (expire) begin state_d = GAP; cnt_d = 16'(NIBBLE_GAP_CYC - 1); end
            GAP:   if (expire) begin state_d = EHI2; cnt_d = 16'(E_HIGH_CYC - 1); end
            EHI2:  if (expire) begin state_d = HOLD; cnt_d = 16'(HOLD_CYC - 1); end
            HOLD:  if (expire) begin
                state_d = repeat_rd ? PGAP : DONE;
                cnt_d   = repeat_rd ? 16'(NIBBLE_GAP_CYC - 1) : 16'd0;
            end
            PGAP:  if (expire) begin state_d = EHI1; cnt_d = 16'(E_HIGH_CYC - 1); end
            default: state_d = IDLE;
        endcase
    end

    // Pin outputs are registered from the next state so E and RW never glitch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 16'd0;
            lcd_e_q     <= 1'b0;
            lcd_rw_q    <= 1'b0;
            lcd_rs_q    <= 1'b0;
            nib_hi_q    <= 4'h0;
            nib_lo_q    <= 4'h0;
            rd_data_q   <= 8'h00;
            busy_flag_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lcd_e_q  <= state_d == EHI1 || state_d == EHI2;
            lcd_rw_q <= state_d != IDLE;
            lcd_rs_q <= state_d == IDLE ? 1'b0 : state_q == IDLE ? rd_rs : lcd_rs_q;
            if (state_q == EHI1 && sample) nib_hi_q <= lcd_db_in;
            if (state_q == EHI2 && sample) nib_lo_q <= lcd_db_in;
            if (state_q == HOLD && expire && !repeat_rd) begin
                rd_data_q <= {nib_hi_q, nib_lo_q};
                if (!lcd_rs_q) busy_flag_q <= nib_hi_q[3];
            end
        end
    end

    assign rd_busy   = state_q != IDLE;
    assign rd_done   = state_q == DONE;
    assign rd_data   = rd_data_q;
    assign busy_flag = busy_flag_q;
    assign lcd_e     = lcd_e_q;
    assign lcd_rs    = lcd_rs_q;
    assign lcd_rw    = lcd_rw_q;
    assign lcd_db_oe = ~lcd_rw_q;
endmodule
